cdc_handshake_sync: RTL and testbench
=====================================

# cdc_handshake_sync

Parametrised multi-bit clock-domain-crossing synchroniser using a 4-phase req/ack handshake. A data word accepted in the clk_a domain is delivered in the clk_b domain as a one-cycle b_valid strobe. The request and acknowledge are single-bit level signals through configurable-depth flop chains, and the data bus is held stable while in flight. It generalises the team's fixed two-flop single-bit synchroniser to arbitrary width, arbitrary depth and a flow-controlled source interface. It sits on every control/status bus crossing between the fabric clock and peripheral clocks.

## Interface
- WIDTH, 8: data word width in bits (≥1).
- SYNC_STAGES, 2: flops per synchroniser chain (≥2; elaboration error if lower).
- RESET_VAL, '0: reset value of b_data (WIDTH bits).

- clk_a  in  1  source-domain clock.
- rst_a  in  1  reset rst_a, asynchronous, active-high; clock clk_a.
- clk_b  in  1  destination-domain clock.
- rst_b  in  1  destination reset, asynchronous, active-high, clk_b domain.
- a_valid  in  1  source has a word; sampled on clk_a.
- a_ready  out  1  source FSM idle; a word is accepted when a_valid & a_ready at a clk_a edge.
- a_data  in  WIDTH  source word; sampled only on acceptance.
- b_valid  out  1  one-clk_b-cycle strobe; b_data is new.
- b_data  out  WIDTH  last delivered word; holds between strobes.

## Operation
- Source FSM (clk_a), states IDLE, REQ, DRAIN:
  - IDLE: a_ready=1. On a_valid, latch a_data into hold register, set req=1, go to REQ.
  - REQ: a_ready=0. Wait for ack_sync_a=1, then clear req and go to DRAIN.
  - DRAIN: a_ready=0. Wait for ack_sync_a=0, then go to IDLE.
- Hold register and req are flops with no combinational path to clk_b logic. The hold register changes only in IDLE on acceptance.
- Destination (clk_b):
  - req passes through SYNC_STAGES flops to give req_sync_b; ack = req_sync_b, registered.
  - On the rising edge of req_sync_b (req_sync_b & !req_sync_d), b_data ← hold register and b_valid=1 for exactly one cycle.
- ack passes through SYNC_STAGES clk_a flops to give ack_sync_a.
- Exactly one b_valid per accepted word. No b_valid without an acceptance, except in the rst_b case below.
- Reset values:
  - a_ready=1 (FSM IDLE), but a_valid is ignored while rst_a is high.
  - b_valid=0, b_data=RESET_VAL.
  - All sync flops, req, ack and the hold register are 0.
- Isolated rst_a mid-transfer: FSM returns to IDLE and req drops. The destination sees req fall, ack falls, and no b_valid is generated for a word still in REQ.
- Isolated rst_b mid-transfer while req=1: the destination clears and then re-detects the req rising edge, so the held word is delivered once more. This is required behaviour. The system normally resets both domains together.

## Timing
- Acceptance at clk_a edge t0: req=1 after t0.
- b_valid rises SYNC_STAGES+1 clk_b edges after the first clk_b edge that samples req=1. Add ±1 clk_b of synchroniser uncertainty in gate-level/metastability models.
- ack rises one clk_b edge after req_sync_b. ack_sync_a rises SYNC_STAGES clk_a edges after that, and FSM leaves REQ on the following edge.
- Full cycle: a_ready returns roughly 2·(SYNC_STAGES+1) clk_a plus 2·(SYNC_STAGES+1) clk_b cycles after acceptance. Back-to-back a_valid is simply stalled by a_ready=0.
- a_data may change freely on any cycle after acceptance.
- Clock ratio unconstrained, since it is a full handshake. Clocks may be equal or either much faster.

## Structure
- Package cdc_pkg:
  - src_state_t enum {IDLE, REQ, DRAIN};
  - localparam MIN_SYNC_STAGES=2.
- Sub-module sync_chain, parameter STAGES, with its own clk, async active-high rst and 1-bit d/q. Instantiated twice: req into clk_b, ack into clk_a.
- All chain flops carry the team's synchroniser attribute for placement/MTBF analysis.

## Test plan
- Reset both, clk_a=100 MHz, clk_b=37 MHz, WIDTH=8: send 0xA5 → one b_valid with b_data=0xA5; a_ready back to 1; b_data holds 0xA5.
- Hold a_valid high with 16 incrementing words 0x00–0x0F → exactly 16 b_valid pulses, in order, no duplicates or drops; a_ready low throughout each transfer.
- Swap clock ratio (clk_b 10× clk_a), SYNC_STAGES=3, WIDTH=32, send 0xDEADBEEF → b_valid latency within the Timing bound; single strobe.
- Assert rst_a for 2 clk_a while in REQ, before b_valid → no b_valid; FSM idle; the next word 0x3C is delivered correctly.
- Assert rst_b for 2 clk_b while req=1 after the first delivery of 0x77 → b_data resets to RESET_VAL, then 0x77 is redelivered exactly once; source completes to IDLE.
- During reset, a_valid=1 with 0xFF → not accepted, no b_valid; b_valid=0 and b_data=RESET_VAL throughout reset.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared types and limits for the req/ack handshake clock-domain crossing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cdc_pkg;

  // Source-side handshake phases.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } src_state_t;

  // Fewer than two flops gives no useful metastability settling time.
  localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_chain.sv
// Single-bit level synchroniser: STAGES flops in the destination clock.
// Latency: STAGES destination clock edges from d to q.
// Backpressure: none; d must be a level that is held long enough to be seen.
module sync_chain
  import cdc_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  if (STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
    $error("sync_chain: STAGES must be at least %0d", MIN_SYNC_STAGES);
  end

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

  // Shift the asynchronous level through the chain; bit 0 is the capture flop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/cdc_handshake_sync.sv
// Multi-bit clk_a -> clk_b crossing using a 4-phase req/ack handshake; word delivered as a one-cycle b_valid strobe.
// Latency: b_valid about SYNC_STAGES+1 clk_b edges after req is first sampled; a_ready returns after ack rises and falls.
// Backpressure: a_ready is low from acceptance until the handshake completes; a_valid is simply stalled meanwhile.
module cdc_handshake_sync
  import cdc_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic             clk_a,
  input  logic             rst_a,
  input  logic             clk_b,
  input  logic             rst_b,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  output logic             b_valid,
  output logic [WIDTH-1:0] b_data
);

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
    $error("cdc_handshake_sync: SYNC_STAGES must be at least %0d", MIN_SYNC_STAGES);
  end

  // clk_a domain state
  src_state_t       r_state;
  logic             r_req;
  logic             r_a_ready;
  logic [WIDTH-1:0] r_hold;
  logic             w_ack_sync_a;

  // clk_b domain state
  logic             r_ack;
  logic             r_b_valid;
  logic [WIDTH-1:0] r_b_data;
  logic             w_req_sync_b;
  logic             w_req_rise;

  // Source FSM: capture the word, raise req, wait for ack to rise, drop req, wait for ack to fall.
  always_ff @(posedge clk_a or posedge rst_a) begin
    if (rst_a) begin
      r_state   <= IDLE;
      r_req     <= 1'b0;
      r_hold    <= '0;
      r_a_ready <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (a_valid) begin
            r_hold    <= a_data;
            r_req     <= 1'b1;
            r_a_ready <= 1'b0;
            r_state   <= REQ;
          end
        end
        REQ: begin
          if (w_ack_sync_a) begin
            r_req   <= 1'b0;
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!w_ack_sync_a) begin
            r_a_ready <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_req     <= 1'b0;
          r_a_ready <= 1'b1;
        end
      endcase
    end
  end

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .i_clk (clk_b),
    .i_rst (rst_b),
    .i_d   (r_req),
    .o_q   (w_req_sync_b)
  );

  // r_ack is req_sync_b delayed by one clk_b cycle, so it also serves as the edge-detect history.
  assign w_req_rise = w_req_sync_b & ~r_ack;

  // Destination: return ack and, on a new request, copy the (by now stable) hold register out.
  always_ff @(posedge clk_b or posedge rst_b) begin
    if (rst_b) begin
      r_ack     <= 1'b0;
      r_b_valid <= 1'b0;
      r_b_data  <= RESET_VAL;
    end else begin
      r_ack     <= w_req_sync_b;
      r_b_valid <= w_req_rise;
      if (w_req_rise) begin
        r_b_data <= r_hold;
      end
    end
  end

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .i_clk (clk_a),
    .i_rst (rst_a),
    .i_d   (r_ack),
    .o_q   (w_ack_sync_a)
  );

  assign a_ready = r_a_ready;
  assign b_valid = r_b_valid;
  assign b_data  = r_b_data;

endmodule

// File: tb/tb_cdc_handshake_sync.sv
// Bench for cdc_handshake_sync: 8-bit instance (clk_a 100 MHz / clk_b 37 MHz) and 32-bit instance (clk_b 10x clk_a).
// Delays are in picoseconds (default time unit).
module tb_cdc_handshake_sync;

  localparam logic [7:0] RV0 = 8'h5C;
  localparam int         SS1 = 3;

  logic clk_a = 1'b0;
  logic clk_b = 1'b0;
  logic clk_f = 1'b0;
  always #5000  clk_a = ~clk_a;
  always #13500 clk_b = ~clk_b;
  always #500   clk_f = ~clk_f;

  logic        rst_a, rst_b, rst_b1;
  logic        a_valid, a_ready, b_valid;
  logic [7:0]  a_data, b_data;
  logic        a_valid1, a_ready1, b_valid1;
  logic [31:0] a_data1, b_data1;

  cdc_handshake_sync #(.WIDTH(8), .SYNC_STAGES(2), .RESET_VAL(RV0)) dut0 (
    .clk_a(clk_a), .rst_a(rst_a), .clk_b(clk_b), .rst_b(rst_b),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_data(b_data)
  );

  cdc_handshake_sync #(.WIDTH(32), .SYNC_STAGES(SS1)) dut1 (
    .clk_a(clk_a), .rst_a(rst_a), .clk_b(clk_f), .rst_b(rst_b1),
    .a_valid(a_valid1), .a_ready(a_ready1), .a_data(a_data1),
    .b_valid(b_valid1), .b_data(b_data1)
  );

  int checks = 0;
  int errors = 0;
  int b_cnt  = 0;
  int b1_cnt = 0;
  logic [7:0]  q0[$];
  logic [31:0] q1[$];

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_dout;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard for the 8-bit instance: every strobe must match the oldest outstanding word.
  always @(posedge clk_b) begin
    #100;
    if (b_valid === 1'b1) begin
      b_cnt++;
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_valid_unexpected: got strobe with data %h, expected none at %0t", b_data, $time);
      end else begin
        chk("b_data_sb", 32'(b_data), 32'(q0.pop_front()));
      end
    end
  end

  // Scoreboard for the 32-bit instance.
  always @(posedge clk_f) begin
    #100;
    if (b_valid1 === 1'b1) begin
      b1_cnt++;
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b1_valid_unexpected: got strobe with data %h, expected none at %0t", b_data1, $time);
      end else begin
        chk("b1_data_sb", b_data1, q1.pop_front());
      end
    end
  end

  // Waits (bounded) until a_ready is seen high at a clk_a negedge.
  task automatic wait_ready();
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk_a);
      if (a_ready === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL a_ready_timeout: got a_ready %b, expected 1 within 1000 cycles", a_ready);
  endtask

  // Waits (bounded) until all expected words are delivered and the source is idle.
  task automatic wait_drain();
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk_a);
      if (q0.size() == 0 && a_ready === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: got %0d outstanding, a_ready %b, expected 0 and 1", q0.size(), a_ready);
  endtask

  // Offers one word; records the expected output at the accepting edge. Leaves a_valid high.
  task automatic send(input logic [7:0] d, input logic [7:0] e);
    wait_ready();
    chk("sb_empty_at_ready", 32'(q0.size()), 32'd0);
    a_data  = d;
    a_valid = 1'b1;
    @(posedge clk_a);
    q0.push_back(e);
    @(negedge clk_a);
    chk("a_ready_busy", 32'(a_ready), 32'd0);
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int n;

    vecs[0] = '{8'hA5, 8'hA5};
    vecs[1] = '{8'h00, 8'h00};
    vecs[2] = '{8'hFF, 8'hFF};
    vecs[3] = '{8'h5A, 8'h5A};
    vecs[4] = '{8'h81, 8'h81};

    // Reset with a word offered: nothing may be accepted or delivered.
    rst_a = 1'b1; rst_b = 1'b1; rst_b1 = 1'b1;
    a_valid = 1'b1; a_data = 8'hFF;
    a_valid1 = 1'b0; a_data1 = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_b);
      chk("rst_b_valid", 32'(b_valid), 32'd0);
      chk("rst_b_data", 32'(b_data), 32'(RV0));
    end
    @(negedge clk_a);
    chk("rst_a_ready", 32'(a_ready), 32'd1);
    chk("rst_b1_data", b_data1, 32'd0);
    a_valid = 1'b0;
    rst_a = 1'b0; rst_b = 1'b0; rst_b1 = 1'b0;
    repeat (20) @(negedge clk_a);
    chk("no_strobe_after_reset", 32'(b_cnt), 32'd0);
    chk("b_data_after_reset", 32'(b_data), 32'(RV0));

    // Single isolated transfers from the vector table.
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].din, vecs[i].exp_dout);
      a_valid = 1'b0;
      wait_drain();
      repeat (10) @(negedge clk_b);
      chk("b_data_hold", 32'(b_data), 32'(vecs[i].exp_dout));
      chk("a_ready_idle", 32'(a_ready), 32'd1);
    end
    chk("single_count", 32'(b_cnt), 32'd5);

    // a_valid held high across 16 incrementing words; data changes right after each acceptance.
    c0 = b_cnt;
    for (int i = 0; i < 16; i++) begin
      send(8'(i), 8'(i));
      a_data = ~8'(i);
    end
    a_valid = 1'b0;
    wait_drain();
    chk("burst_count", 32'(b_cnt - c0), 32'd16);
    chk("burst_last", 32'(b_data), 32'h0F);

    // Fast destination, 3 stages, 32-bit word: latency and single strobe.
    @(negedge clk_a);
    chk("b1_ready", 32'(a_ready1), 32'd1);
    a_data1  = 32'hDEADBEEF;
    a_valid1 = 1'b1;
    @(posedge clk_a);
    q1.push_back(32'hDEADBEEF);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk_f);
      n++;
      #100;
      if (k == 0) begin
        a_valid1 = 1'b0;
        a_data1  = 32'h0;
      end
      if (b_valid1 === 1'b1) break;
    end
    checks++;
    if (!(b_valid1 === 1'b1 && n >= SS1 && n <= SS1 + 2)) begin
      errors++;
      $display("FAIL b1_latency: got strobe %b after %0d clk_b edges, required %0d..%0d",
               b_valid1, n, SS1, SS1 + 2);
    end
    for (int k = 0; k < 500; k++) begin
      @(negedge clk_a);
      if (a_ready1 === 1'b1) break;
    end
    chk("b1_ready_back", 32'(a_ready1), 32'd1);
    repeat (20) @(negedge clk_a);
    chk("b1_single_strobe", 32'(b1_cnt), 32'd1);
    chk("b1_data_hold", b_data1, 32'hDEADBEEF);

    // rst_a pulse right after acceptance, before the destination can sample req.
    c0 = b_cnt;
    @(posedge clk_b);
    @(negedge clk_a);
    a_data  = 8'h99;
    a_valid = 1'b1;
    @(posedge clk_a);
    #1000;
    rst_a   = 1'b1;
    a_valid = 1'b0;
    #1000;
    chk("rsta_idle_in_reset", 32'(a_ready), 32'd1);
    repeat (2) @(posedge clk_a);
    #1000;
    rst_a = 1'b0;
    repeat (30) @(negedge clk_a);
    chk("rsta_no_strobe", 32'(b_cnt - c0), 32'd0);
    chk("rsta_fsm_idle", 32'(a_ready), 32'd1);
    chk("rsta_b_data_kept", 32'(b_data), 32'h0F);
    send(8'h3C, 8'h3C);
    a_valid = 1'b0;
    wait_drain();
    chk("rsta_next_word", 32'(b_data), 32'h3C);

    // rst_b pulse just after the first delivery, while req is still high: exactly one redelivery.
    c0 = b_cnt;
    send(8'h77, 8'h77);
    a_valid = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk_b);
      #200;
      if (b_valid === 1'b1) break;
    end
    chk("rstb_first_delivery", 32'(b_valid), 32'd1);
    rst_b = 1'b1;
    q0.push_back(8'h77);
    repeat (2) @(posedge clk_b);
    #200;
    chk("rstb_valid_low", 32'(b_valid), 32'd0);
    chk("rstb_data_reset", 32'(b_data), 32'(RV0));
    chk("rstb_src_waiting", 32'(a_ready), 32'd0);
    rst_b = 1'b0;
    wait_drain();
    repeat (40) @(negedge clk_b);
    chk("rstb_two_strobes", 32'(b_cnt - c0), 32'd2);
    chk("rstb_redelivered", 32'(b_data), 32'h77);
    chk("rstb_src_idle", 32'(a_ready), 32'd1);

    chk("q0_empty_end", 32'(q0.size()), 32'd0);
    chk("q1_empty_end", 32'(q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
